sdram_rd_channel_sched: RTL and testbench

- Round-robin scheduler for the SDRAM read path, serving 20 channel FIFOs.
- Samples each channel's ready flag, picks the next eligible channel after the last one served, and drives the channel index onto the shared select bus.
- Issues one fixed-length read burst request to the SDRAM controller and counts data beats until the burst completes.
- Sits between the per-channel FIFO ready flags and the SDRAM read engine; owns the channel select bus.

---
 rtl/sdram_sched_pkg.sv | 20 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/sdram_rd_channel_sched.sv | 117 +++++++++++
 tb/tb_sdram_rd_channel_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared constants for the SDRAM read-channel scheduler: FSM encodings,
// default channel geometry and the counter-width helper.
package sdram_sched_pkg;

  localparam int NUM_CH_DEF = 20;
  localparam int CH_W_DEF   = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t SCAN = 2'd1;
  localparam state_t REQ  = 2'd2;
  localparam state_t XFER = 2'd3;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: the first set request strictly after `last`,
// wrapping around, found by rotate / priority-encode / un-rotate.
module rr_pick #(
  parameter int NUM_CH = 20,
  parameter int CH_W   = 8
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  // One extra bit so start+offset (< 2*NUM_CH) never overflows.
  localparam int SW = CH_W + 1;

  logic [SW-1:0]       start;
  logic [SW-1:0]       off;
  logic [SW-1:0]       sum;
  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;

  always_comb begin
    start = ({1'b0, last} >= SW'(NUM_CH - 1)) ? '0 : {1'b0, last} + SW'(1);
    dbl   = {req, req};
    rot   = NUM_CH'(dbl >> start);
    found = 1'b0;
    off   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SW'(i);
      end
    end
    sum = start + off;
    if (sum >= SW'(NUM_CH)) begin
      sum = sum - SW'(NUM_CH);
    end
    idx = sum[CH_W-1:0];
  end

endmodule

// File: rtl/sdram_rd_channel_sched.sv
// Round-robin read-burst scheduler: picks the next ready channel, holds it on
// the select bus, requests one fixed-length burst and counts its beats.
module sdram_rd_channel_sched
  import sdram_sched_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int CH_W      = CH_W_DEF,
  parameter int BURST_LEN = 256,
  parameter int TMO_CYC   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ready_vec,
  output logic [CH_W-1:0]   channel,
  output logic              rd_req,
  input  logic              rd_gnt,
  input  logic              rd_beat,
  output logic              busy,
  output logic              burst_done,
  output logic              tmo_err,
  output logic [CH_W-1:0]   last_ch
);

  localparam int BEAT_W = cnt_w(BURST_LEN + 1);
  localparam int TMO_W  = cnt_w(TMO_CYC);

  state_t            state_reg;
  logic [BEAT_W-1:0] beat_cnt_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic [CH_W-1:0]   channel_reg;
  logic [CH_W-1:0]   last_ch_reg;
  logic              rd_req_reg;
  logic              burst_done_reg;
  logic              tmo_err_reg;

  logic              pick_found;
  logic [CH_W-1:0]   pick_idx;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req   (ready_vec),
    .last  (last_ch_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      beat_cnt_reg   <= '0;
      tmo_cnt_reg    <= '0;
      channel_reg    <= '0;
      last_ch_reg    <= CH_W'(NUM_CH - 1);
      rd_req_reg     <= 1'b0;
      burst_done_reg <= 1'b0;
      tmo_err_reg    <= 1'b0;
    end else begin
      burst_done_reg <= 1'b0;
      tmo_err_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable && (|ready_vec)) begin
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          // Ready may have vanished since IDLE; then nothing is latched.
          if (pick_found) begin
            channel_reg <= pick_idx;
            last_ch_reg <= pick_idx;
            rd_req_reg  <= 1'b1;
            state_reg   <= REQ;
          end else begin
            state_reg <= IDLE;
          end
        end
        REQ: begin
          if (rd_gnt) begin
            rd_req_reg   <= 1'b0;
            beat_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
            state_reg    <= XFER;
          end
        end
        XFER: begin
          // A beat on the threshold cycle takes precedence over the timeout.
          if (rd_beat) begin
            tmo_cnt_reg <= '0;
            if (beat_cnt_reg == BEAT_W'(BURST_LEN - 1)) begin
              burst_done_reg <= 1'b1;
              state_reg      <= IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            end
          end else if (tmo_cnt_reg == TMO_W'(TMO_CYC - 1)) begin
            tmo_err_reg <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign channel    = channel_reg;
  assign last_ch    = last_ch_reg;
  assign rd_req     = rd_req_reg;
  assign burst_done = burst_done_reg;
  assign tmo_err    = tmo_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_sdram_rd_channel_sched.sv
// Directed bench for the round-robin SDRAM read scheduler (20 channels,
// 256-beat bursts, 16-cycle beat timeout).
module tb_sdram_rd_channel_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [19:0] ready_vec;
  logic [7:0]  channel;
  logic        rd_req;
  logic        rd_gnt;
  logic        rd_beat;
  logic        busy;
  logic        burst_done;
  logic        tmo_err;
  logic [7:0]  last_ch;

  int vectors = 0;
  int miscompares = 0;

  sdram_rd_channel_sched #(
    .NUM_CH    (20),
    .CH_W      (8),
    .BURST_LEN (256),
    .TMO_CYC   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ready_vec  (ready_vec),
    .channel    (channel),
    .rd_req     (rd_req),
    .rd_gnt     (rd_gnt),
    .rd_beat    (rd_beat),
    .busy       (busy),
    .burst_done (burst_done),
    .tmo_err    (tmo_err),
    .last_ch    (last_ch)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  // Waits (bounded) for rd_req, grants, then delivers beats; reports observations.
  task automatic run_burst(input int beats, input int gap_at, input int gap,
                           input bit toggle, input int drop_en_at,
                           output int ch, output bit got_req, output int wait_cyc,
                           output bit done, output bit stable, output bit tmo_seen,
                           output bit early);
    got_req = 0; wait_cyc = 0; done = 0; stable = 1; tmo_seen = 0; early = 0; ch = -1;
    for (int i = 0; i < 60; i++) begin
      if (rd_req) begin
        got_req = 1;
        break;
      end
      @(posedge clk); #1;
      wait_cyc++;
    end
    if (!got_req) begin
      $display("burst: no rd_req seen");
      return;
    end
    ch = int'(channel);
    rd_gnt = 1'b1;
    @(posedge clk); #1;
    rd_gnt = 1'b0;
    for (int k = 0; k < beats; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          if (tmo_err) tmo_seen = 1;
          if (int'(channel) != ch) stable = 0;
        end
      end
      if (k == drop_en_at) enable = 1'b0;
      if (toggle) ready_vec = k[0] ? 20'h00A00 : 20'h00300;
      rd_beat = 1'b1;
      @(posedge clk); #1;
      rd_beat = 1'b0;
      if (tmo_err) tmo_seen = 1;
      if (int'(channel) != ch) stable = 0;
      if (k < beats - 1 && burst_done) early = 1;
    end
    done = burst_done;
    $display("burst: ch=%0d wait=%0d beats=%0d done=%0b tmo=%0b", ch, wait_cyc, beats, done, tmo_seen);
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; ready_vec = '0; rd_gnt = 1'b0; rd_beat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (channel !== 8'd0) begin miscompares++; $display("FAIL reset_channel: got %0d want 0", channel); end
    vectors++; if (rd_req !== 1'b0) begin miscompares++; $display("FAIL reset_rd_req: got %0b want 0", rd_req); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vectors++; if (burst_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b want 0", burst_done); end
    vectors++; if (tmo_err !== 1'b0) begin miscompares++; $display("FAIL reset_tmo: got %0b want 0", tmo_err); end
    vectors++; if (last_ch !== 8'd19) begin miscompares++; $display("FAIL reset_last_ch: got %0d want 19", last_ch); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int ch, wc; bit gr, dn, st, tm, ea;
    ready_vec = 20'h00001; enable = 1'b1;
    run_burst(256, -1, 0, 0, -1, ch, gr, wc, dn, st, tm, ea);
    enable = 1'b0;
    vectors++; if (gr !== 1'b1) begin miscompares++; $display("FAIL single_req: got %0b want 1", gr); end
    vectors++; if (wc !== 2) begin miscompares++; $display("FAIL single_latency: got %0d want 2", wc); end
    vectors++; if (ch !== 0) begin miscompares++; $display("FAIL single_ch: got %0d want 0", ch); end
    vectors++; if (dn !== 1'b1 || ea !== 1'b0) begin miscompares++; $display("FAIL single_done: got done=%0b early=%0b want 1/0", dn, ea); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %0b want 0", busy); end
    vectors++; if (last_ch !== 8'd0) begin miscompares++; $display("FAIL single_last_ch: got %0d want 0", last_ch); end
    @(posedge clk); #1;
    vectors++; if (burst_done !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse: got %0b want 0", burst_done); end
  endtask

  task automatic test_round_robin;
    int ch, wc; bit gr, dn, st, tm, ea;
    int exp_a[4] = '{0, 1, 2, 3};
    int exp_b[3] = '{19, 2, 19};
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_vec = 20'hFFFFF; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_burst(256, -1, 0, 0, -1, ch, gr, wc, dn, st, tm, ea);
      vectors++; if (ch !== exp_a[i]) begin miscompares++; $display("FAIL rr_all_ch[%0d]: got %0d want %0d", i, ch, exp_a[i]); end
      vectors++; if (wc !== 2 || dn !== 1'b1) begin miscompares++; $display("FAIL rr_all_turn[%0d]: got wait=%0d done=%0b want 2/1", i, wc, dn); end
    end
    ready_vec = 20'h80004;
    for (int i = 0; i < 3; i++) begin
      run_burst(256, -1, 0, 0, -1, ch, gr, wc, dn, st, tm, ea);
      vectors++; if (ch !== exp_b[i]) begin miscompares++; $display("FAIL rr_wrap_ch[%0d]: got %0d want %0d", i, ch, exp_b[i]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_drop_mid;
    int ch, wc; bit gr, dn, st, tm, ea;
    ready_vec = 20'h00220; enable = 1'b1;
    run_burst(256, -1, 0, 1, -1, ch, gr, wc, dn, st, tm, ea);
    ready_vec = 20'h00208;
    vectors++; if (ch !== 5) begin miscompares++; $display("FAIL drop_ch: got %0d want 5", ch); end
    vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL drop_stable: got %0b want 1", st); end
    vectors++; if (dn !== 1'b1) begin miscompares++; $display("FAIL drop_done: got %0b want 1", dn); end
    run_burst(256, -1, 0, 0, -1, ch, gr, wc, dn, st, tm, ea);
    enable = 1'b0;
    vectors++; if (ch !== 9) begin miscompares++; $display("FAIL drop_next_ch: got %0d want 9", ch); end
  endtask

  task automatic test_timeout;
    int ch, wc; bit gr, dn, st, tm, ea;
    int n = 0;
    bit bd = 0;
    ready_vec = 20'h01010; enable = 1'b1;
    run_burst(10, -1, 0, 0, -1, ch, gr, wc, dn, st, tm, ea);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (burst_done) bd = 1;
      if (tmo_err) begin
        n = i;
        break;
      end
    end
    vectors++; if (ch !== 12) begin miscompares++; $display("FAIL tmo_ch: got %0d want 12", ch); end
    vectors++; if (n !== 16) begin miscompares++; $display("FAIL tmo_delay: got %0d want 16", n); end
    vectors++; if (bd !== 1'b0 || dn !== 1'b0) begin miscompares++; $display("FAIL tmo_no_done: got %0b want 0", bd | dn); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tmo_idle: got busy=%0b want 0", busy); end
    vectors++; if (last_ch !== 8'd12) begin miscompares++; $display("FAIL tmo_last_ch: got %0d want 12", last_ch); end
    @(posedge clk); #1;
    vectors++; if (tmo_err !== 1'b0) begin miscompares++; $display("FAIL tmo_pulse: got %0b want 0", tmo_err); end
    run_burst(256, -1, 0, 0, -1, ch, gr, wc, dn, st, tm, ea);
    enable = 1'b0;
    vectors++; if (ch !== 4 || dn !== 1'b1) begin miscompares++; $display("FAIL tmo_next: got ch=%0d done=%0b want 4/1", ch, dn); end
  endtask

  task automatic test_beat_vs_tmo;
    int ch, wc; bit gr, dn, st, tm, ea;
    ready_vec = 20'h00010; enable = 1'b1;
    run_burst(256, 1, 15, 0, -1, ch, gr, wc, dn, st, tm, ea);
    enable = 1'b0;
    vectors++; if (ch !== 4) begin miscompares++; $display("FAIL race_ch: got %0d want 4", ch); end
    vectors++; if (tm !== 1'b0) begin miscompares++; $display("FAIL race_tmo: got %0b want 0", tm); end
    vectors++; if (dn !== 1'b1 || ea !== 1'b0) begin miscompares++; $display("FAIL race_done: got done=%0b early=%0b want 1/0", dn, ea); end
  endtask

  task automatic test_req_hold;
    int ch, wc; bit gr, dn, st, tm, ea;
    bit dropped = 0;
    bit tmo_hit = 0;
    ready_vec = 20'h00080; enable = 1'b1;
    for (int i = 0; i < 10 && !rd_req; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 40; i++) begin
      rd_beat = i[0];
      @(posedge clk); #1;
      if (!rd_req) dropped = 1;
      if (tmo_err) tmo_hit = 1;
    end
    rd_beat = 1'b0;
    vectors++; if (dropped !== 1'b0) begin miscompares++; $display("FAIL req_hold: got rd_req dropped=%0b want 0", dropped); end
    vectors++; if (tmo_hit !== 1'b0) begin miscompares++; $display("FAIL req_no_tmo: got %0b want 0", tmo_hit); end
    run_burst(256, -1, 0, 0, -1, ch, gr, wc, dn, st, tm, ea);
    enable = 1'b0;
    vectors++; if (ch !== 7 || dn !== 1'b1 || ea !== 1'b0) begin miscompares++; $display("FAIL req_burst: got ch=%0d done=%0b early=%0b want 7/1/0", ch, dn, ea); end
    rd_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rd_gnt = 1'b0;
    vectors++; if (busy !== 1'b0 || rd_req !== 1'b0) begin miscompares++; $display("FAIL gnt_idle: got busy=%0b rd_req=%0b want 0/0", busy, rd_req); end
  endtask

  task automatic test_enable_mid;
    int ch, wc; bit gr, dn, st, tm, ea;
    bit active = 0;
    ready_vec = 20'h00002; enable = 1'b1;
    run_burst(256, -1, 0, 0, 100, ch, gr, wc, dn, st, tm, ea);
    vectors++; if (ch !== 1 || dn !== 1'b1) begin miscompares++; $display("FAIL en_burst: got ch=%0d done=%0b want 1/1", ch, dn); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rd_req || busy) active = 1;
    end
    vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL en_hold_idle: got %0b want 0", active); end
    enable = 1'b1;
    run_burst(256, -1, 0, 0, -1, ch, gr, wc, dn, st, tm, ea);
    enable = 1'b0;
    vectors++; if (wc !== 2 || ch !== 1) begin miscompares++; $display("FAIL en_resume: got wait=%0d ch=%0d want 2/1", wc, ch); end
  endtask

  task automatic test_reset_mid;
    int ch, wc; bit gr, dn, st, tm, ea;
    ready_vec = 20'h00041; enable = 1'b1;
    run_burst(100, -1, 0, 0, -1, ch, gr, wc, dn, st, tm, ea);
    vectors++; if (ch !== 6 || dn !== 1'b0) begin miscompares++; $display("FAIL rstmid_pre: got ch=%0d done=%0b want 6/0", ch, dn); end
    #3;
    rst = 1'b1;
    #1;
    vectors++; if (channel !== 8'd0 || last_ch !== 8'd19) begin miscompares++; $display("FAIL rstmid_idx: got ch=%0d last=%0d want 0/19", channel, last_ch); end
    vectors++; if (busy !== 1'b0 || rd_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctl: got busy=%0b rd_req=%0b want 0/0", busy, rd_req); end
    vectors++; if (burst_done !== 1'b0 || tmo_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_pulse: got done=%0b tmo=%0b want 0/0", burst_done, tmo_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_burst(256, -1, 0, 0, -1, ch, gr, wc, dn, st, tm, ea);
    enable = 1'b0;
    vectors++; if (ch !== 0 || dn !== 1'b1) begin miscompares++; $display("FAIL rstmid_after: got ch=%0d done=%0b want 0/1", ch, dn); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop_mid();
    test_timeout();
    test_beat_vs_tmo();
    test_req_hold();
    test_enable_mid();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
